seg_game_ctrl: RTL and testbench

//  Game controller that sits directly downstream of the delay stage and consumes its finish level.

---
 rtl/seg_game_pkg.sv | 21 ++
 rtl/seg_game_ctrl_if.sv | 24 ++
 rtl/seg_game_ctrl_rise_pulse.sv | 25 ++
 rtl/seg_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_seg_game_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_game_pkg.sv
// Shared types and constants for the seven-segment reaction game controller.
// Holds the FSM state type, fixed segment patterns and the ring-position decoder.
package seg_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_G   = 7'h40;
  localparam logic [6:0] SEG_ALL = 7'h7F;

  // Ring position p lights outer segment p (0=a .. 5=f).
  function automatic logic [6:0] ring_seg(input logic [2:0] pos);
    ring_seg = 7'h01 << pos;
  endfunction

endpackage

// File: rtl/seg_game_ctrl_if.sv
// Link between the game controller (master) and the delay stage (slave):
// the expiry level coming back and the enable/load/restart controls going out.
interface seg_game_ctrl_if;

  logic finish;
  logic delay_en;
  logic load_delay;
  logic delay_restart;

  modport master (
    input  finish,
    output delay_en,
    output load_delay,
    output delay_restart
  );

  modport slave (
    output finish,
    input  delay_en,
    input  load_delay,
    input  delay_restart
  );

endinterface

// File: rtl/seg_game_ctrl_rise_pulse.sv
// Rising-edge detector for an already synchronised, debounced button level.
// One flop remembers the previous level; the pulse lasts exactly one cycle per press.
module rise_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic btn_q;
  logic btn_d;

  always_comb begin
    btn_d = btn_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn_d;
  end

  // Suppressed during reset so no restart pulse leaks out while rst_n is low.
  assign pulse_o = btn_i & ~btn_q & rst_n;

endmodule

// File: rtl/seg_game_ctrl.sv
// Reaction game controller: steps a lit segment around the display ring on each delay expiry.
// Optional build macro SEG_GAME_HIT_FLASH_EN lights all segments after a scoring hit until the next step.
module seg_game_ctrl
  import seg_game_pkg::*;
#(
  parameter int unsigned NUM_POS    = 6,
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned MAX_MISS   = 3,
  parameter int unsigned TARGET_POS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               hit_btn,
  seg_game_ctrl_if.master    dly,
  output logic [6:0]         seg,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam logic [2:0]         LAST_POS  = 3'(NUM_POS - 1);
  localparam logic [2:0]         TGT_POS   = 3'(TARGET_POS);
  localparam logic [2:0]         MISS_LIM  = 3'(MAX_MISS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_q, state_d;
  logic [2:0]         pos_q, pos_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         miss_q, miss_d;
  logic               armed_q, armed_d;
  logic               start_p, hit_p;
  logic               score_hit;
  logic               show_all;

  rise_pulse u_start_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (start_btn),
    .pulse_o (start_p)
  );

  rise_pulse u_hit_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (hit_btn),
    .pulse_o (hit_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= 3'd0;
      score_q <= '0;
      miss_q  <= 3'd0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      armed_q <= armed_d;
    end
  end

  // Hits are judged against the pre-advance position, also during STEP, so the
  // miss limit is checked on the updated count before leaving RUN or STEP.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    score_d   = score_q;
    miss_d    = miss_q;
    armed_d   = armed_q;
    score_hit = 1'b0;

    if ((state_q == RUN || state_q == STEP) && hit_p && armed_q) begin
      armed_d = 1'b0;
      if (pos_q == TGT_POS) begin
        score_hit = 1'b1;
        if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
      end else begin
        miss_d = miss_q + 3'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = RUN;
          pos_d   = 3'd0;
          score_d = '0;
          miss_d  = 3'd0;
          armed_d = 1'b1;
        end
      end
      RUN: begin
        if (miss_d == MISS_LIM) state_d = OVER;
        else if (dly.finish)    state_d = STEP;
      end
      STEP: begin
        pos_d   = (pos_q == LAST_POS) ? 3'd0 : pos_q + 3'd1;
        armed_d = 1'b1;
        state_d = (miss_d == MISS_LIM) ? OVER : RUN;
      end
      OVER: begin
        if (start_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEG_GAME_HIT_FLASH_EN
  logic flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    if (score_hit) flash_d = 1'b1;
    if (state_q == STEP || (state_q == IDLE && start_p)) flash_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flash_q <= 1'b0;
    else        flash_q <= flash_d;
  end

  assign show_all = flash_q;
`else
  assign show_all = 1'b0;
`endif

  always_comb begin
    dly.delay_en      = 1'b0;
    dly.load_delay    = 1'b0;
    dly.delay_restart = 1'b0;
    seg               = SEG_OFF;
    case (state_q)
      IDLE: begin
        dly.load_delay    = 1'b1;
        dly.delay_restart = start_p;
      end
      RUN: begin
        dly.delay_en = 1'b1;
        seg          = show_all ? SEG_ALL : ring_seg(pos_q);
      end
      STEP: begin
        dly.delay_restart = 1'b1;
        seg               = show_all ? SEG_ALL : ring_seg(pos_q);
      end
      OVER: seg = SEG_G;
      default: seg = SEG_OFF;
    endcase
  end

  assign score     = score_q;
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_seg_game_ctrl.sv
// Self-checking bench for seg_game_ctrl: directed game scenarios with literal expectations,
// then randomized button traffic compared every cycle against a behavioural game model.
module tb_seg_game_ctrl;

  localparam int NUM_POS    = 6;
  localparam int SCORE_W    = 4;
  localparam int MAX_MISS   = 3;
  localparam int TARGET_POS = 0;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_OVER = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_btn = 1'b0;
  logic               hit_btn = 1'b0;
  logic [6:0]         seg;
  logic [SCORE_W-1:0] score;
  logic               game_over;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  seg_game_ctrl_if dly_if ();

  seg_game_ctrl #(
    .NUM_POS    (NUM_POS),
    .SCORE_W    (SCORE_W),
    .MAX_MISS   (MAX_MISS),
    .TARGET_POS (TARGET_POS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_btn (start_btn),
    .hit_btn   (hit_btn),
    .dly       (dly_if),
    .seg       (seg),
    .score     (score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Delay stage stand-in: counts enabled cycles up to the period, then holds
  // finish high until the controller restarts it.
  int dly_period = 4;
  int dly_cnt = 0;
  int rs_count = 0;

  always @(posedge clk) begin
    if (!rst_n)                     dly_cnt <= 0;
    else if (dly_if.delay_restart)  dly_cnt <= 0;
    else if (dly_if.delay_en && dly_cnt < dly_period) dly_cnt <= dly_cnt + 1;
  end

  assign dly_if.finish = (dly_cnt >= dly_period);

  // Counts restart pulses so a lap can be checked for one restart per step.
  always @(negedge clk) begin
    if (dly_if.delay_restart) rs_count <= rs_count + 1;
  end

  // Behavioural game model: the game rules as plain integer bookkeeping.
  int m_mode = M_IDLE;
  int m_pos = 0;
  int m_score = 0;
  int m_miss = 0;
  bit m_armed = 1'b1;
  bit m_flash = 1'b0;
  bit m_sprev = 1'b0;
  bit m_hprev = 1'b0;

  task automatic model_step();
    bit se, he;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pos = 0; m_score = 0; m_miss = 0;
      m_armed = 1'b1; m_flash = 1'b0; m_sprev = 1'b0; m_hprev = 1'b0;
      return;
    end
    se = start_btn && !m_sprev;
    he = hit_btn && !m_hprev;
    m_sprev = start_btn;
    m_hprev = hit_btn;
    if (m_mode == M_RUN || m_mode == M_STEP) begin
      if (he && m_armed) begin
        m_armed = 1'b0;
        if (m_pos == TARGET_POS) begin
          if (m_score < SCORE_MAX) m_score++;
          m_flash = 1'b1;
        end else begin
          m_miss++;
        end
      end
      if (m_mode == M_STEP) begin
        m_pos   = (m_pos + 1) % NUM_POS;
        m_armed = 1'b1;
        m_flash = 1'b0;
        m_mode  = (m_miss >= MAX_MISS) ? M_OVER : M_RUN;
      end else if (m_miss >= MAX_MISS) begin
        m_mode = M_OVER;
      end else if (dly_if.finish) begin
        m_mode = M_STEP;
      end
    end else if (m_mode == M_IDLE) begin
      if (se) begin
        m_mode = M_RUN; m_pos = 0; m_score = 0; m_miss = 0;
        m_armed = 1'b1; m_flash = 1'b0;
      end
    end else if (se) begin
      m_mode = M_IDLE;
    end
  endtask

  always @(posedge clk) model_step();

  // Every cycle after the first reset, compare all outputs with the model.
  task automatic compare_model();
    logic [6:0]         e_seg;
    logic [SCORE_W-1:0] e_score;
    logic               e_en, e_ld, e_rs, e_go;
    bit                 flash_on;
`ifdef SEG_GAME_HIT_FLASH_EN
    flash_on = m_flash;
`else
    flash_on = 1'b0;
`endif
    e_seg   = (m_mode == M_IDLE) ? 7'h00 :
              (m_mode == M_OVER) ? 7'h40 :
              flash_on ? 7'h7F : 7'(1 << m_pos);
    e_en    = (m_mode == M_RUN);
    e_ld    = (m_mode == M_IDLE);
    e_rs    = (m_mode == M_STEP) || (m_mode == M_IDLE && rst_n && start_btn && !m_sprev);
    e_go    = (m_mode == M_OVER);
    e_score = SCORE_W'(m_score);
    checks++;
    if (seg !== e_seg || dly_if.delay_en !== e_en || dly_if.load_delay !== e_ld ||
        dly_if.delay_restart !== e_rs || game_over !== e_go || score !== e_score) begin
      errors++;
      $display("[TB] FAIL model_cmp t=%0t got seg=%h en=%b ld=%b rs=%b go=%b score=%0d want seg=%h en=%b ld=%b rs=%b go=%b score=%0d",
               $time, seg, dly_if.delay_en, dly_if.load_delay, dly_if.delay_restart, game_over, score,
               e_seg, e_en, e_ld, e_rs, e_go, e_score);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) compare_model();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out got=no_event want=event t=%0t", name, $time);
  endtask

  // Drives one cycle of button levels shortly after the active edge.
  task automatic applyStimulus(input logic s, input logic h);
    @(posedge clk);
    #2;
    start_btn = s;
    hit_btn   = h;
  endtask

  task automatic pressStart();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic pressHit();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic waitChange(input string name, input int budget);
    logic [6:0] cur;
    int n;
    cur = seg;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (seg !== cur) return;
    end
    timeoutFail(name);
  endtask

  task automatic waitSeg(input string name, input logic [6:0] target);
    int n;
    n = 0;
    while (seg !== target && n < 8) begin
      waitChange(name, 40);
      n++;
    end
    if (seg !== target) timeoutFail(name);
  endtask

  // Raises hit in the very cycle finish is high, so both land on one edge.
  task automatic hitOnFinish(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #2;
      start_btn = 1'b0;
      hit_btn   = dly_if.finish;
      if (dly_if.finish) break;
      n++;
    end
    if (!hit_btn) timeoutFail(name);
    applyStimulus(1'b0, 1'b0);
  endtask

  logic [6:0] lap_exp [6] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h01};

  initial begin
    int rs_base;
    logic [6:0] hold_seg;

    repeat (3) applyStimulus(1'b0, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    repeat (5) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_seg", 32'(seg), 32'h00);
    checkOutput("idle_delay_en", 32'(dly_if.delay_en), 0);
    checkOutput("idle_load_delay", 32'(dly_if.load_delay), 1);
    checkOutput("idle_game_over", 32'(game_over), 0);

    // One full lap at a 4-cycle delay.
    dly_period = 4;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("start_restart", 32'(dly_if.delay_restart), 1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("run_seg_pos0", 32'(seg), 32'h01);
    rs_base = rs_count;
    for (int k = 0; k < 6; k++) begin
      waitChange("lap_step", 20);
      checkOutput("lap_seg", 32'(seg), 32'(lap_exp[k]));
    end
    checkOutput("lap_restarts", 32'(rs_count - rs_base), 6);

    // Scoring hit at the target, repeat press ignored, then score again next lap.
    dly_period = 8;
    pressHit();
    @(negedge clk);
    checkOutput("hit_score1", 32'(score), 1);
    pressHit();
    @(negedge clk);
    checkOutput("rehit_score", 32'(score), 1);
`ifdef SEG_GAME_HIT_FLASH_EN
    hold_seg = 7'h7F;
`else
    hold_seg = 7'h01;
`endif
    checkOutput("rehit_same_pos", 32'(seg), 32'(hold_seg));
    for (int k = 0; k < 6; k++) waitChange("lap2_step", 40);
    checkOutput("lap2_seg", 32'(seg), 32'h01);
    pressHit();
    @(negedge clk);
    checkOutput("hit_score2", 32'(score), 2);

    // Three misses end the game.
    waitSeg("miss_pos1", 7'h02);
    pressHit();
    waitSeg("miss_pos2", 7'h04);
    pressHit();
    waitSeg("miss_pos3", 7'h08);
    pressHit();
    @(negedge clk);
    checkOutput("over_game_over", 32'(game_over), 1);
    checkOutput("over_seg", 32'(seg), 32'h40);
    checkOutput("over_delay_en", 32'(dly_if.delay_en), 0);
    checkOutput("over_score", 32'(score), 2);
    pressStart();
    @(negedge clk);
    checkOutput("back_idle_ld", 32'(dly_if.load_delay), 1);
    checkOutput("back_idle_score", 32'(score), 2);
    pressStart();
    @(negedge clk);
    checkOutput("restart_score", 32'(score), 0);
    checkOutput("restart_seg", 32'(seg), 32'h01);

    // Hit coinciding with finish: at the target it scores, at pos 5 it misses.
    hitOnFinish("finish_hit_pos0");
    @(negedge clk);
    checkOutput("fh0_score", 32'(score), 1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fh0_next_seg", 32'(seg), 32'h02);
    waitSeg("reach_pos5", 7'h20);
    hitOnFinish("finish_hit_pos5");
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fh5_next_seg", 32'(seg), 32'h01);
    checkOutput("fh5_score", 32'(score), 1);

    // Reset in the middle of a game.
    applyStimulus(1'b0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_seg", 32'(seg), 32'h00);
    checkOutput("rst_delay_en", 32'(dly_if.delay_en), 0);
    checkOutput("rst_load_delay", 32'(dly_if.load_delay), 1);
    checkOutput("rst_score", 32'(score), 0);
    rst_n = 1'b1;

    // Randomized play against the model, a fresh reset and delay per chunk.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0);
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      dly_period = int'($urandom_range(2, 7));
      rst_n = 1'b1;
      for (int i = 0; i < 400; i++) begin
        logic s, h;
        s = ($urandom_range(0, 29) == 0);
        h = ($urandom_range(0, 3) == 0) ? ~hit_btn : hit_btn;
        applyStimulus(s, h);
      end
    end

    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog got=still_running want=finished t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
